// File: rtl/fp16_mul_byte_io_pkg.sv
// Shared types and widths for the FP16 multiplier byte-serial front/back end.
package fp16_io_pkg;

  localparam int FP16_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    LOAD_A0,
    LOAD_A1,
    LOAD_B0,
    LOAD_B1,
    CAPTURE,
    SEND0,
    SEND1
  } io_state_t;

endpackage

// File: rtl/fp16_mul_byte_io_if.sv
// Byte buses, multiplier hookup and status for fp16_mul_byte_io.
// master = surrounding environment, slave = the fp16_mul_byte_io block.
interface fp16_mul_byte_io_if;
  import fp16_io_pkg::*;

  logic              clear;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [FP16_W-1:0] op_a;
  logic [FP16_W-1:0] op_b;
  logic [FP16_W-1:0] mul_result;
  logic              mul_ok;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              nan_flag;
  logic              busy;

  modport master (
    output clear, in_data, in_valid, mul_result, mul_ok, out_ready,
    input  in_ready, op_a, op_b, out_data, out_valid, nan_flag, busy
  );

  modport slave (
    input  clear, in_data, in_valid, mul_result, mul_ok, out_ready,
    output in_ready, op_a, op_b, out_data, out_valid, nan_flag, busy
  );

endinterface

// File: rtl/fp16_mul_byte_io.sv
// Byte-serial operand loader and result streamer around an external
// combinational FP16 multiplier. Operands are held on op_a/op_b while the
// multiplier settles, then the captured result is sent out byte by byte.
module fp16_mul_byte_io
  import fp16_io_pkg::*;
#(
  parameter int MSB_FIRST     = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input logic              clock,
  input logic              reset,
  fp16_mul_byte_io_if.slave bus
);

  localparam logic       B0_HI       = (MSB_FIRST != 0);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  io_state_t         state_q, state_d;
  logic [3:0]        cnt_q;
  logic [FP16_W-1:0] op_a_q, op_b_q, res_q;
  logic              nan_q;

  logic in_ready_w, out_valid_w;
  logic in_xfer, out_xfer, settle_done, load_hi;

  assign in_xfer     = bus.in_valid & in_ready_w;
  assign out_xfer    = out_valid_w & bus.out_ready;
  assign settle_done = (state_q == CAPTURE) && (cnt_q == SETTLE_LAST);
  // Second byte of each operand goes to the opposite half from the first.
  assign load_hi     = ((state_q == LOAD_A1) || (state_q == LOAD_B1)) ^ B0_HI;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= LOAD_A0;
    else       state_q <= state_d;
  end

  // Next-state logic; clear overrides any transfer in the same cycle.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = LOAD_A0;
    end else begin
      case (state_q)
        LOAD_A0: if (in_xfer)     state_d = LOAD_A1;
        LOAD_A1: if (in_xfer)     state_d = LOAD_B0;
        LOAD_B0: if (in_xfer)     state_d = LOAD_B1;
        LOAD_B1: if (in_xfer)     state_d = CAPTURE;
        CAPTURE: if (settle_done) state_d = SEND0;
        SEND0:   if (out_xfer)    state_d = SEND1;
        SEND1:   if (out_xfer)    state_d = LOAD_A0;
        default:                  state_d = LOAD_A0;
      endcase
    end
  end

  // Settle counter, operand halves, result capture and NaN flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      res_q  <= '0;
      nan_q  <= 1'b0;
    end else if (bus.clear) begin
      cnt_q <= '0;
      nan_q <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        cnt_q <= settle_done ? '0 : cnt_q + 4'd1;
      end
      if (settle_done) begin
        res_q <= bus.mul_result;
        nan_q <= ~bus.mul_ok;
      end
      if (in_xfer) begin
        if ((state_q == LOAD_A0) || (state_q == LOAD_A1)) begin
          if (load_hi) op_a_q[15:8] <= bus.in_data;
          else         op_a_q[7:0]  <= bus.in_data;
        end else begin
          if (load_hi) op_b_q[15:8] <= bus.in_data;
          else         op_b_q[7:0]  <= bus.in_data;
        end
      end
    end
  end

  // Outputs decoded from registered state and result only.
  always_comb begin
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    bus.busy     = 1'b0;
    bus.out_data = '0;
    case (state_q)
      LOAD_A0, LOAD_A1, LOAD_B0, LOAD_B1: in_ready_w = 1'b1;
      CAPTURE: bus.busy = 1'b1;
      SEND0: begin
        out_valid_w  = 1'b1;
        bus.busy     = 1'b1;
        bus.out_data = B0_HI ? res_q[15:8] : res_q[7:0];
      end
      SEND1: begin
        out_valid_w  = 1'b1;
        bus.busy     = 1'b1;
        bus.out_data = B0_HI ? res_q[7:0] : res_q[15:8];
      end
      default: ;
    endcase
    bus.in_ready  = in_ready_w;
    bus.out_valid = out_valid_w;
    bus.op_a      = op_a_q;
    bus.op_b      = op_b_q;
    bus.nan_flag  = nan_q;
  end

endmodule

// File: tb/tb_fp16_mul_byte_io.sv
// Bench for fp16_mul_byte_io: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a
// transaction-level model.
module tb_fp16_mul_byte_io;
  localparam int MSB    = 0;
  localparam int SETTLE = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic chk_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fp16_mul_byte_io_if bus();

  fp16_mul_byte_io #(.MSB_FIRST(MSB), .SETTLE_CYCLES(SETTLE)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Simple FP16 multiply (normals, truncation); {ok, result}.
  function automatic logic [16:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        nan, s;
    int          ea, eb, e;
    logic [21:0] p;
    logic [9:0]  m;
    logic [15:0] r;
    ea  = int'(a[14:10]);
    eb  = int'(b[14:10]);
    nan = (ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0);
    s   = a[15] ^ b[15];
    if (nan) r = 16'h7E00;
    else if (ea == 31 || eb == 31) r = {s, 15'h7C00};
    else if (ea == 0 || eb == 0) r = {s, 15'h0000};
    else begin
      p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e = ea + eb - 15;
      if (p[21]) begin m = p[20:11]; e++; end
      else m = p[19:10];
      if (e >= 31) r = {s, 15'h7C00};
      else if (e <= 0) r = {s, 15'h0000};
      else r = {s, 5'(e), m};
    end
    return {~nan, r};
  endfunction

  assign {bus.mul_ok, bus.mul_result} = fmul(bus.op_a, bus.op_b);

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 = taking bytes, 1 = waiting, 2 = sending.
  int          m_phase, m_nb, m_wait, m_sidx;
  logic [15:0] m_a, m_b, m_res;
  logic        m_nan;

  always @(posedge clock or posedge reset) begin
    automatic int          ph = m_phase, nb = m_nb, wt = m_wait, si = m_sidx;
    automatic logic [15:0] a = m_a, b = m_b, r = m_res;
    automatic logic        nan = m_nan, hi;
    automatic logic [16:0] f;
    if (reset) begin
      ph = 0; nb = 0; wt = 0; si = 0; a = '0; b = '0; r = '0; nan = 1'b0;
    end else if (bus.clear) begin
      ph = 0; nb = 0; wt = 0; si = 0; nan = 1'b0;
    end else if (ph == 0) begin
      if (bus.in_valid) begin
        hi = ((nb % 2) == 1) != (MSB != 0);
        if (nb < 2) begin
          if (hi) a[15:8] = bus.in_data; else a[7:0] = bus.in_data;
        end else begin
          if (hi) b[15:8] = bus.in_data; else b[7:0] = bus.in_data;
        end
        nb++;
        if (nb == 4) begin ph = 1; wt = SETTLE; end
      end
    end else if (ph == 1) begin
      wt--;
      if (wt == 0) begin
        f = fmul(a, b);
        r = f[15:0]; nan = ~f[16]; ph = 2; si = 0;
      end
    end else begin
      if (bus.out_ready) begin
        si++;
        if (si == 2) begin ph = 0; nb = 0; end
      end
    end
    m_phase <= ph; m_nb <= nb; m_wait <= wt; m_sidx <= si;
    m_a <= a; m_b <= b; m_res <= r; m_nan <= nan;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    automatic logic [7:0] exp_d = 8'h00;
    if (chk_on && !reset) begin
      if (m_phase == 2)
        exp_d = (((m_sidx == 1) != (MSB != 0))) ? m_res[15:8] : m_res[7:0];
      chk("m_in_ready", 16'(bus.in_ready), 16'(m_phase == 0));
      chk("m_out_valid", 16'(bus.out_valid), 16'(m_phase == 2));
      chk("m_busy", 16'(bus.busy), 16'(m_phase != 0));
      chk("m_out_data", 16'(bus.out_data), 16'(exp_d));
      chk("m_op_a", bus.op_a, m_a);
      chk("m_op_b", bus.op_b, m_b);
      chk("m_nan_flag", 16'(bus.nan_flag), 16'(m_nan));
    end
  end

  task automatic push(input logic [7:0] d);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin @(negedge clock); guard++; end
    chk("push_ready", 16'(bus.in_ready), 16'd1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b);
    if (MSB != 0) begin push(a[15:8]); push(a[7:0]); push(b[15:8]); push(b[7:0]); end
    else          begin push(a[7:0]); push(a[15:8]); push(b[7:0]); push(b[15:8]); end
  endtask

  task automatic wait_capture();
    for (int k = 0; k < SETTLE; k++) begin
      chk("cap_busy", 16'(bus.busy), 16'd1);
      chk("cap_no_valid", 16'(bus.out_valid), 16'd0);
      @(negedge clock);
    end
    chk("cap_valid_rise", 16'(bus.out_valid), 16'd1);
  endtask

  task automatic pop(input logic [7:0] exp);
    chk("pop_valid", 16'(bus.out_valid), 16'd1);
    chk("pop_data", 16'(bus.out_data), 16'(exp));
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic pop_word(input logic [15:0] w);
    if (MSB != 0) begin pop(w[15:8]); pop(w[7:0]); end
    else          begin pop(w[7:0]); pop(w[15:8]); end
  endtask

  initial begin
    bus.clear = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    #10 reset = 1'b0;
    @(negedge clock);
    chk_on = 1'b1;
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_data", 16'(bus.out_data), 16'h00);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_nan", 16'(bus.nan_flag), 16'd0);
    chk("rst_op_a", bus.op_a, 16'h0000);

    // 1.0 x 1.0
    load(16'h3C00, 16'h3C00);
    chk("one_op_a", bus.op_a, 16'h3C00);
    chk("one_op_b", bus.op_b, 16'h3C00);
    wait_capture();
    chk("one_nan", 16'(bus.nan_flag), 16'd0);
    pop(8'h00); pop(8'h3C);
    chk("one_back_ready", 16'(bus.in_ready), 16'd1);

    // 2.0 x 3.0 with backpressure in SEND0
    load(16'h4000, 16'h4200);
    wait_capture();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_data", 16'(bus.out_data), 16'h00);
      @(negedge clock);
    end
    pop(8'h00); pop(8'h46);

    // NaN operand; in_valid pulses during CAPTURE are ignored
    load(16'h7E00, 16'h3C00);
    bus.in_data = 8'hFF; bus.in_valid = 1'b1;
    wait_capture();
    bus.in_valid = 1'b0;
    chk("nan_op_a", bus.op_a, 16'h7E00);
    chk("nan_op_b", bus.op_b, 16'h3C00);
    chk("nan_flag", 16'(bus.nan_flag), 16'd1);
    pop(8'h00); pop(8'h7E);
    chk("nan_hold", 16'(bus.nan_flag), 16'd1);

    // clear during a LOAD_B0 transfer
    push(8'h00); push(8'h3C);
    bus.in_data = 8'h55; bus.in_valid = 1'b1; bus.clear = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0; bus.clear = 1'b0;
    chk("clr_ready", 16'(bus.in_ready), 16'd1);
    chk("clr_op_b", bus.op_b, 16'h3C00);
    chk("clr_nan", 16'(bus.nan_flag), 16'd0);
    load(16'h3C00, 16'h3C00);
    wait_capture();
    pop_word(16'h3C00);

    // asynchronous reset mid-SEND1
    load(16'h4000, 16'h4200);
    wait_capture();
    pop(8'h00);
    chk("pre_rst_valid", 16'(bus.out_valid), 16'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", 16'(bus.out_valid), 16'd0);
    chk("arst_data", 16'(bus.out_data), 16'h00);
    chk("arst_op_a", bus.op_a, 16'h0000);
    chk("arst_op_b", bus.op_b, 16'h0000);
    chk("arst_ready", 16'(bus.in_ready), 16'd1);
    #1 reset = 1'b0;
    @(negedge clock);

    // random traffic, checked by the per-cycle model comparison
    for (int c = 0; c < 4000; c++) begin
      bus.in_valid  = ($urandom % 10) < 7;
      bus.in_data   = 8'($urandom);
      if (($urandom % 6) == 0) bus.in_data = 8'h7E;
      bus.out_ready = ($urandom % 10) < 6;
      bus.clear     = ($urandom % 60) == 0;
      @(negedge clock);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.clear = 1'b0;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp16_mul_byte_io.md
Name: fp16_mul_byte_io

Overview:
Sequential front/back end for the combinational FP16 multiplier `mul`, for the pin-limited tapeout top.
- Collects two FP16 operands from an 8-bit input bus, one byte per handshake.
- Holds the operands stable on `op_a`/`op_b` while the multiplier settles.
- Captures `mul_out` and `mul_valid` into registers.
- Streams the 16-bit result back out over an 8-bit output bus with ready/valid flow control.

Parameters:
- MSB_FIRST, default 0: byte order on both buses. 0 = low byte first, 1 = high byte first.
- SETTLE_CYCLES, default 2, legal range 1..15: cycles the operands are held before the result is sampled. Covers the multiplier's combinational depth.

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort; return to operand load
- in_data  input  8  operand byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts a byte this cycle
- op_a  output  16  operand A, driven to mul.input_a
- op_b  output  16  operand B, driven to mul.input_b
- mul_result  input  16  from mul.mul_out
- mul_ok  input  1  from mul.mul_valid (0 = NaN operand)
- out_data  output  8  result byte
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data
- nan_flag  output  1  registered ~mul_ok of the last captured result
- busy  output  1  high in CAPTURE, SEND0 and SEND1

Behaviour:
Reset values (asynchronous, while reset=1):
- State = LOAD_A0; op_a, op_b, result register, settle counter = 0; nan_flag = 0.
- Outputs: in_ready = 1, out_valid = 0, out_data = 0x00, busy = 0.

State sequence:
- LOAD_A0 -> LOAD_A1 -> LOAD_B0 -> LOAD_B1 -> CAPTURE -> SEND0 -> SEND1 -> LOAD_A0.

Load states:
- in_ready = 1 exactly in LOAD_* states, combinationally from state.
- A transfer happens when in_valid & in_ready. It writes the byte into the addressed half of op_a or op_b and advances the state. With no transfer, the state holds.
- Byte 0 is bits [7:0] when MSB_FIRST=0, and bits [15:8] when MSB_FIRST=1. Byte 1 is the other half.
- op_a/op_b change only on their own load transfers. They stay stable from the final LOAD_B1 transfer until the next LOAD_A0 transfer, i.e. through CAPTURE and the whole send phase.

CAPTURE:
- On entry, the settle counter is 0. It increments each cycle.
- When counter == SETTLE_CYCLES-1, that cycle's edge does three things:
  - latches mul_result into the result register;
  - sets nan_flag <= ~mul_ok;
  - moves to SEND0 and zeroes the counter.
- CAPTURE therefore lasts exactly SETTLE_CYCLES cycles.
- in_valid is ignored in this state.

Latency:
- From the LOAD_B1 transfer edge to out_valid rising is SETTLE_CYCLES+1 edges.
- For SETTLE_CYCLES=2, out_valid is high 3 edges after the last input transfer.

SEND0 / SEND1:
- out_valid = 1. out_data = result byte 0 in SEND0 and byte 1 in SEND1, registered with no combinational path from inputs.
- The state advances on out_valid & out_ready.
- While out_ready = 0, out_data and out_valid hold unchanged.
- out_data = 0x00 in all other states.

NaN:
- The result bytes are still sent as produced.
- nan_flag holds its value until the next capture, clear, or reset.

clear:
- Takes priority over any same-cycle transfer.
- Next state = LOAD_A0, counter = 0, nan_flag = 0.
- op_a/op_b keep their values until overwritten by loads.
- Any partially sent result is discarded.

Reset mid-operation:
- Immediate return to reset values. No byte is emitted after reset asserts.

Arithmetic:
- Counter width is 4 bits, compared against the parameter truncated to 4 bits.
- There are no other arithmetic paths.

Decomposition:
- Package fp16_io_pkg:
  - typedef enum logic [2:0] io_state_t {LOAD_A0, LOAD_A1, LOAD_B0, LOAD_B1, CAPTURE, SEND0, SEND1};
  - localparams FP16_W = 16, BYTE_W = 8.
- Single module; no sub-module.
- The multiplier is instantiated beside this block in the tapeout top, not inside it.

Test Plan:
- Bytes 00,3C,00,3C (MSB_FIRST=0), out_ready=1 -> op_a = op_b = 0x3C00; after 3 edges out_valid=1; out_data 0x00 then 0x3C; nan_flag = 0; returns to LOAD_A0 with in_ready=1.
- Bytes 00,40,00,42 (2.0 × 3.0) -> out_data 0x00 then 0x46 (6.0 = 0x4600).
- A = 0x7E00, B = 0x3C00 -> nan_flag = 1 after capture; in_valid pulses during CAPTURE are ignored and op_a/op_b are unchanged.
- Backpressure: hold out_ready=0 for 5 cycles in SEND0 -> out_valid=1 and out_data=0x00 stable; release -> 0x46 follows on the next cycle.
- clear asserted in the same cycle as a LOAD_B0 transfer -> state LOAD_A0, that byte not written, nan_flag = 0; the full 1.0 × 1.0 sequence then succeeds.
- Asynchronous reset pulse mid-SEND1 (off-edge) -> out_valid drops immediately; op_a = op_b = 0; in_ready = 1.
